// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial transmitter: valid/ready word capture, one bit per clock on `a`.
// Optional even-parity trailer bit enabled by defining SERIAL_TX_PARITY_EN.
module serial_tx_shifter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             a,
    output logic             a_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 2);
    localparam bit MSB = (MSB_FIRST != 0);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PARITY
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE,
        S_SHIFT
    } state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_a;
    logic             r_a_valid;
    logic             r_busy;
    logic             r_done;
    logic             w_a_nxt;
    logic             w_a_valid_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_last;
    logic             w_hs;
    logic             w_first_bit;
    logic             w_next_bit;
`ifdef SERIAL_TX_PARITY_EN
    logic             r_par;
    logic             w_par_nxt;
`endif

    assign w_last      = (r_state == S_SHIFT) && (r_cnt == LAST);
    assign w_hs        = in_valid && in_ready;
    assign w_first_bit = MSB ? in_data[WIDTH-1] : in_data[0];
    assign w_next_bit  = MSB ? r_shift[WIDTH-2] : r_shift[1];

    // Ready depends only on state/counter so there is no in_valid -> in_ready path.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE:   in_ready = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                S_SHIFT:  in_ready = 1'b0;
                S_PARITY: in_ready = 1'b1;
`else
                S_SHIFT:  in_ready = w_last;
`endif
                default:  in_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
`ifdef SERIAL_TX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = w_hs ? S_SHIFT : S_IDLE;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                w_state_nxt = w_hs ? S_SHIFT : S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The first bit is driven straight from in_data at the handshake edge, so the
    // shift register always holds the full word and the next bit sits one position in.
    always_comb begin
        w_a_nxt       = 1'b0;
        w_a_valid_nxt = 1'b0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_cnt;
`ifdef SERIAL_TX_PARITY_EN
        w_par_nxt     = r_par;
`endif
        if (w_hs) begin
            w_a_nxt       = w_first_bit;
            w_a_valid_nxt = 1'b1;
            w_busy_nxt    = 1'b1;
            w_shift_nxt   = in_data;
            w_cnt_nxt     = '0;
`ifdef SERIAL_TX_PARITY_EN
            w_par_nxt     = ^in_data;
`endif
        end else begin
            case (r_state)
                S_SHIFT: begin
                    if (!w_last) begin
                        w_a_nxt       = w_next_bit;
                        w_a_valid_nxt = 1'b1;
                        w_busy_nxt    = 1'b1;
                        w_shift_nxt   = MSB ? (r_shift << 1) : (r_shift >> 1);
                        w_cnt_nxt     = r_cnt + CW'(1);
`ifdef SERIAL_TX_PARITY_EN
                        w_done_nxt    = 1'b0;
`else
                        w_done_nxt    = (r_cnt == LAST_M1);
`endif
                    end else begin
                        w_shift_nxt = '0;
                        w_cnt_nxt   = '0;
`ifdef SERIAL_TX_PARITY_EN
                        w_a_nxt       = r_par;
                        w_a_valid_nxt = 1'b1;
                        w_busy_nxt    = 1'b1;
                        w_done_nxt    = 1'b1;
`endif
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_par_nxt   = 1'b0;
                end
`endif
                default: begin
                    w_cnt_nxt = r_cnt;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_a       <= 1'b0;
            r_a_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_a       <= w_a_nxt;
            r_a_valid <= w_a_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
`ifdef SERIAL_TX_PARITY_EN
            r_par     <= w_par_nxt;
`endif
        end
    end

    assign a       = r_a;
    assign a_valid = r_a_valid;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Bench for serial_tx_shifter: MSB-first and LSB-first instances share one stimulus
// stream and are compared against a queue of expected serial slots.
module tb_serial_tx_shifter;

    localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic rdy_m, a_m, av_m, busy_m, done_m;
    logic rdy_l, a_l, av_l, busy_l, done_l;

    always #5 clk = ~clk;

    serial_tx_shifter #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_m), .a(a_m), .a_valid(av_m), .busy(busy_m), .done(done_m)
    );

    serial_tx_shifter #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_l), .a(a_l), .a_valid(av_l), .busy(busy_l), .done(done_l)
    );

    // One entry per output cycle: expected bit for each bit order and the done flag.
    typedef struct packed {
        logic idle;
        logic b_m;
        logic b_l;
        logic dn;
    } slot_t;

    slot_t       q[$];
    slot_t       cur;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    function automatic slot_t idle_slot();
        slot_t s;
        s      = '0;
        s.idle = 1'b1;
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic push_word(input logic [W-1:0] d);
        for (int k = 0; k < W; k++) begin
            slot_t s;
            s.idle = 1'b0;
            s.b_m  = d[W-1-k];
            s.b_l  = d[k];
            s.dn   = (k == W - 1) && !PAR;
            q.push_back(s);
        end
        if (PAR) begin
            slot_t p;
            p.idle = 1'b0;
            p.b_m  = ^d;
            p.b_l  = ^d;
            p.dn   = 1'b1;
            q.push_back(p);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy_m"}, rdy_m, 0);  check({tag, "_rdy_l"}, rdy_l, 0);
        check({tag, "_a_m"}, a_m, 0);      check({tag, "_a_l"}, a_l, 0);
        check({tag, "_av_m"}, av_m, 0);    check({tag, "_av_l"}, av_l, 0);
        check({tag, "_busy_m"}, busy_m, 0); check({tag, "_busy_l"}, busy_l, 0);
        check({tag, "_done_m"}, done_m, 0); check({tag, "_done_l"}, done_l, 0);
    endtask

    task automatic run_cycle(input logic v, input logic [W-1:0] d);
        logic exp_rdy;
        logic hs;
        @(negedge clk);
        exp_rdy = cur.idle || cur.dn;
        check("rdy_m", rdy_m, exp_rdy);
        check("rdy_l", rdy_l, exp_rdy);
        check("a_msb", a_m, cur.idle ? 1'b0 : cur.b_m);
        check("a_lsb", a_l, cur.idle ? 1'b0 : cur.b_l);
        check("valid_m", av_m, !cur.idle);
        check("valid_l", av_l, !cur.idle);
        check("busy_m", busy_m, !cur.idle);
        check("busy_l", busy_l, !cur.idle);
        check("done_m", done_m, cur.dn);
        check("done_l", done_l, cur.dn);
        in_valid = v;
        in_data  = d;
        hs = v && exp_rdy;
        @(posedge clk);
        if (hs) push_word(d);
        cur = (q.size() > 0) ? q.pop_front() : idle_slot();
    endtask

    // Called just after a rising edge: reset lands mid-cycle and must clear outputs at once.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        q.delete();
        cur      = idle_slot();
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        cur      = idle_slot();
        #12 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        run_cycle(1'b1, 8'hA5);
        repeat (10) run_cycle(1'b0, W'($urandom));
        run_cycle(1'b1, 8'h01);
        repeat (10) run_cycle(1'b0, '0);

        run_cycle(1'b1, 8'hFF);
        repeat (7) run_cycle(1'b1, 8'hFF);
        run_cycle(1'b1, 8'h00);
        repeat (11) run_cycle(1'b0, '0);

        run_cycle(1'b1, 8'hF0);
        run_cycle(1'b0, 8'h0F);
        run_cycle(1'b1, 8'h0F);
        repeat (10) run_cycle(1'b0, 8'h0F);

        run_cycle(1'b1, 8'hC3);
        repeat (3) run_cycle(1'b0, '0);
        mid_reset();
        run_cycle(1'b1, 8'h81);
        repeat (10) run_cycle(1'b0, '0);

        run_cycle(1'b1, 8'h07);
        repeat (10) run_cycle(1'b0, '0);

        for (int i = 0; i < 800; i++) begin
            run_cycle($urandom_range(0, 3) != 0, W'($urandom));
            if ($urandom_range(0, 149) == 0) mid_reset();
        end
        repeat (12) run_cycle(1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
